pulse_meter: RTL

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures period (rise to rise) and high time (rise to fall) of a pulse train.
// Define PULSE_METER_SYNC_EN to insert a two-flop input synchronizer (adds 2 cycles of latency).
module pulse_meter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high,
  output logic             valid,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic sig_in;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= signal;
      sync2_q <= sync1_q;
    end
  end

  assign sig_in = sync2_q;
`else
  assign sig_in = signal;
`endif

  state_e           state_q, state_d;
  logic             s_q, s_d, s_prev_q, s_prev_d;
  logic [WIDTH-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, overflow_q, overflow_d;

  logic             rise, fall;
  logic             p_sat, h_sat;
  logic [WIDTH-1:0] p_inc, h_inc;

  assign rise  = s_q & ~s_prev_q;
  assign fall  = ~s_q & s_prev_q;
  assign p_sat = (cnt_p_q == CntMax);
  assign h_sat = (cnt_h_q == CntMax);
  // Saturating increments; a blocked increment is recorded in ovf.
  assign p_inc = p_sat ? CntMax : cnt_p_q + CntOne;
  assign h_inc = h_sat ? CntMax : cnt_h_q + CntOne;

  always_comb begin
    s_d        = sig_in;
    s_prev_d   = s_q;
    state_d    = state_q;
    cnt_p_d    = cnt_p_q;
    cnt_h_d    = cnt_h_q;
    ovf_d      = ovf_q;
    period_d   = period_q;
    high_d     = high_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          cnt_p_d = CntOne;
          cnt_h_d = CntOne;
          ovf_d   = 1'b0;
        end
      end
      StHigh: begin
        cnt_p_d = p_inc;
        if (fall) begin
          ovf_d   = ovf_q | p_sat;
          state_d = StLow;
        end else begin
          cnt_h_d = h_inc;
          ovf_d   = ovf_q | p_sat | h_sat;
        end
      end
      StLow: begin
        if (rise) begin
          period_d   = cnt_p_q;
          high_d     = cnt_h_q;
          overflow_d = ovf_q;
          valid_d    = 1'b1;
          cnt_p_d    = CntOne;
          cnt_h_d    = CntOne;
          ovf_d      = 1'b0;
          state_d    = StHigh;
        end else begin
          cnt_p_d = p_inc;
          ovf_d   = ovf_q | p_sat;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      s_q        <= 1'b0;
      s_prev_q   <= 1'b0;
      cnt_p_q    <= '0;
      cnt_h_q    <= '0;
      ovf_q      <= 1'b0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      s_prev_q   <= s_prev_d;
      cnt_p_q    <= cnt_p_d;
      cnt_h_q    <= cnt_h_d;
      ovf_q      <= ovf_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign period   = period_q;
  assign high     = high_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule
